ramp_adc_sequencer: RTL and testbench

- Conversion controller for the single-slope ramp ADC datapath: comparator, free counter and value capture.
- Scans a programmable set of analog channels and, per channel, drives the analog mux select, the ramp discharge and the ramp enable.
- Times the comparator edge with its own WIDTH-bit counter and returns one tagged result per channel over a valid/ready handshake.

---
 rtl/ramp_adc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ramp_adc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_adc_sequencer.sv
// Single-slope ramp ADC sequencer: scans enabled channels, times the comparator
// edge against a local counter and hands back one tagged code per channel.
module ramp_adc_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             continuous,
  input  logic             comp_out,
  output logic             ramp_rst,
  output logic             ramp_en,
  output logic [CH_W-1:0]  ch_sel,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_ovf
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] FullScale = '1;
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StRamp, StHold, StNext} state_e;

  state_e           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             comp_q, comp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic             ovf_q, ovf_d;
  logic             ramp_rst_q, ramp_en_q, busy_q, valid_q;

  logic             low_found, nxt_found;
  logic [CH_W-1:0]  low_idx, nxt_idx;

  // Lowest set bit of the live mask, and next enabled channel above the current one.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!low_found && chan_mask[i]) begin
        low_found = 1'b1;
        low_idx   = CH_W'(i);
      end
      if (!nxt_found && mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = CH_W'(i);
      end
    end
  end

  // Next-state logic for the scan FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    comp_d   = comp_q;
    data_d   = data_q;
    rch_d    = rch_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start && low_found) begin
          mask_d   = chan_mask;
          ch_d     = low_idx;
          settle_d = '0;
          state_d  = StSelect;
        end
      end
      StSelect: begin
        cnt_d  = '0;
        comp_d = 1'b0;
        if (settle_q == SettleLast) begin
          state_d = StRamp;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRamp: begin
        comp_d = comp_out;
        if (comp_out && !comp_q) begin
          // An edge on the full-scale count still counts as a valid code.
          data_d  = cnt_q;
          ovf_d   = 1'b0;
          rch_d   = ch_q;
          state_d = StHold;
        end else if (cnt_q == FullScale) begin
          data_d  = FullScale;
          ovf_d   = 1'b1;
          rch_d   = ch_q;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        // res_valid is high for the whole of HOLD, so ready alone completes it.
        if (res_ready) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (nxt_found) begin
          ch_d     = nxt_idx;
          settle_d = '0;
          state_d  = StSelect;
        end else if (continuous && low_found) begin
          mask_d   = chan_mask;
          ch_d     = low_idx;
          settle_d = '0;
          state_d  = StSelect;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      ch_q       <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      comp_q     <= 1'b0;
      data_q     <= '0;
      rch_q      <= '0;
      ovf_q      <= 1'b0;
      ramp_rst_q <= 1'b1;
      ramp_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      comp_q     <= comp_d;
      data_q     <= data_d;
      rch_q      <= rch_d;
      ovf_q      <= ovf_d;
      ramp_rst_q <= (state_d != StRamp);
      ramp_en_q  <= (state_d == StRamp);
      busy_q     <= (state_d != StIdle);
      valid_q    <= (state_d == StHold);
    end
  end

  assign ramp_rst  = ramp_rst_q;
  assign ramp_en   = ramp_en_q;
  assign ch_sel    = ch_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_ch    = rch_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_ramp_adc_sequencer.sv
// Bench for ramp_adc_sequencer: a comparator stand-in fires at a per-channel
// threshold count; a result-level model predicts codes, order and timing.
module tb_ramp_adc_sequencer;

  localparam int WIDTH  = 8;
  localparam int NCH    = 4;
  localparam int CH_W   = 2;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst, start, continuous, comp_out, res_ready;
  logic [NCH-1:0]   chan_mask;
  logic             ramp_rst, ramp_en, busy, res_valid, res_ovf;
  logic [CH_W-1:0]  ch_sel, res_ch;
  logic [WIDTH-1:0] res_data;

  ramp_adc_sequencer #(
    .WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
    .continuous(continuous), .comp_out(comp_out), .ramp_rst(ramp_rst),
    .ramp_en(ramp_en), .ch_sel(ch_sel), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int data; int ovf; int len;} exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   thr [NCH];   // ramp count at which the comparator trips; >255 never trips
  exp_t q[$];        // expected results, in order
  exp_t log_q[$];    // observed results, for literal spot checks

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one result per set mask bit, ascending; code is the threshold capped at full scale.
  function automatic void push_scan(input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        int code;
        code = (thr[i] > 255) ? 255 : thr[i];
        q.push_back('{i, code, (thr[i] > 255) ? 1 : 0, code + 1});
      end
    end
  endfunction

  // Comparator stand-in: tracks the ramp count and trips at the selected channel's threshold.
  int   ridx = 0;
  logic ramp_prev = 1'b0;
  initial comp_out = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ramp_en) begin
      ridx = ramp_prev ? ridx + 1 : 0;
      comp_out = (ridx >= thr[ch_sel]);
    end else begin
      comp_out = 1'($urandom_range(0, 1));  // must be ignored outside RAMP
    end
    ramp_prev = ramp_en;
  end

  // Per-cycle compare against the result model.
  int   gap = 0, rlen = 0, tail = 0, n_done = 0, rfirst = 0, rlast = 0;
  logic first = 1'b1, pv = 1'b0, pready = 1'b0, pramp = 1'b0, po = 1'b0;
  int   pd = 0, pc = 0;
  always @(negedge clk) begin
    if (rst) begin
      first = 1'b1; gap = 0; rlen = 0; tail = 0;
      pv = 1'b0; pready = 1'b0; pramp = 1'b0;
    end else begin
      chk("ramp_rst_vs_ramp_en", ramp_rst, !ramp_en);
      if (ramp_en || res_valid) chk("busy_when_active", busy, 1);
      if (res_valid) chk("ramp_off_in_hold", ramp_en, 0);
      if (!busy) begin
        first = 1'b1;
        gap = 0;
      end
      if (tail == 2) begin
        chk("busy_in_next", busy, 1);
        tail = 1;
      end else if (tail == 1) begin
        chk("idle_after_scan", busy, 0);
        tail = 0;
      end
      if (ramp_en && !pramp) begin
        chk("settle_gap", gap, first ? SETTLE : SETTLE + 1);
        gap = 0; first = 1'b0; rlen = 0; rfirst = cyc;
      end
      if (ramp_en) begin
        rlen++;
        rlast = cyc;
        if (q.size() > 0) chk("ch_sel", ch_sel, q[0].ch);
      end else if (busy && !res_valid) begin
        gap++;
      end
      if (pv && !pready) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, pd);
        chk("hold_ch", res_ch, pc);
        chk("hold_ovf", res_ovf, po);
      end
      if (pv && pready) chk("valid_drop", res_valid, 0);
      if (res_valid && !pv) begin
        chk("valid_follows_ramp", pramp, 1);
        log_q.push_back('{int'(res_ch), int'(res_data), int'(res_ovf), rlen});
        if (q.size() == 0) begin
          chk("unexpected_result", 0, 1);
        end else begin
          chk("ramp_len", rlen, q[0].len);
          chk("res_data", res_data, q[0].data);
          chk("res_ch", res_ch, q[0].ch);
          chk("res_ovf", res_ovf, q[0].ovf);
        end
      end
      if (res_valid && res_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        n_done++;
        if (q.size() == 0) tail = 2;
      end
      pv = res_valid; pready = res_ready; pramp = ramp_en;
      pd = res_data; pc = res_ch; po = res_ovf;
    end
  end

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < max_cyc);
    chk(name, int'(busy) + q.size(), 0);
  endtask

  task automatic kick(input logic [NCH-1:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    chan_mask = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ramp_rst"}, ramp_rst, 1);
    chk({tag, "_ramp_en"}, ramp_en, 0);
    chk({tag, "_ch_sel"}, ch_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_ch"}, res_ch, 0);
    chk({tag, "_res_ovf"}, res_ovf, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, base;
    rst = 1'b1; start = 1'b0; chan_mask = '0; continuous = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < NCH; i++) thr[i] = 256;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Single channel, edge on the 38th ramp cycle, consumer slow to accept.
    thr[0] = 37; log_q.delete(); push_scan(4'b0001);
    @(posedge clk); #1;
    start = 1'b1; chan_mask = 4'b0001; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 100);
    chk("t1_valid_cycle", cyc - t0, 43);
    chk("t1_data", res_data, 37);
    chk("t1_ch", res_ch, 0);
    chk("t1_ovf", res_ovf, 0);
    chk("t1_ramp_first", rfirst - t0, 5);
    chk("t1_ramp_last", rlast - t0, 42);
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle(20, "t1_idle");

    // Scan order over mask 1010 with ready tied high.
    thr[1] = 10; thr[3] = 200; log_q.delete(); push_scan(4'b1010);
    kick(4'b1010);
    wait_idle(600, "t2_idle");
    chk("t2_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_ch0", log_q[0].ch, 1);
      chk("t2_data0", log_q[0].data, 10);
      chk("t2_ch1", log_q[1].ch, 3);
      chk("t2_data1", log_q[1].data, 200);
    end

    // Overflow, then an edge exactly at full scale.
    thr[0] = 256; log_q.delete(); push_scan(4'b0001);
    kick(4'b0001);
    wait_idle(400, "t3a_idle");
    thr[0] = 255; push_scan(4'b0001);
    kick(4'b0001);
    wait_idle(400, "t3b_idle");
    chk("t3_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t3_ovf_data", log_q[0].data, 255);
      chk("t3_ovf_flag", log_q[0].ovf, 1);
      chk("t3_ovf_len", log_q[0].len, 256);
      chk("t3_edge_data", log_q[1].data, 255);
      chk("t3_edge_flag", log_q[1].ovf, 0);
    end

    // Immediate edge, then 20 cycles of backpressure.
    thr[2] = 0; res_ready = 1'b0; log_q.delete(); push_scan(4'b0100);
    kick(4'b0100);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    repeat (20) @(negedge clk);
    chk("t4_valid_held", res_valid, 1);
    chk("t4_data", res_data, 0);
    chk("t4_ch", res_ch, 2);
    chk("t4_ramp_off", ramp_en, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle(20, "t4_idle");

    // Continuous scans with an ignored mid-scan start and mask change.
    thr[0] = 5; thr[1] = 7; log_q.delete();
    push_scan(4'b0011); push_scan(4'b0011); push_scan(4'b0011);
    base = n_done;
    @(posedge clk); #1;
    continuous = 1'b1; start = 1'b1; chan_mask = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; chan_mask = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0; chan_mask = 4'b0011;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(n_done - base == 4 && ramp_en) && n < 400);
    chk("t5_third_scan_reached", n_done - base, 4);
    continuous = 1'b0;
    wait_idle(400, "t5_idle");
    chk("t5_count", log_q.size(), 6);
    for (int i = 0; i < log_q.size(); i++) chk("t5_order", log_q[i].ch, i % 2);
    @(posedge clk); #1;
    start = 1'b1; chan_mask = 4'b0000;
    @(posedge clk); #1;
    start = 1'b0; chan_mask = 4'b0011;
    repeat (5) begin
      @(negedge clk);
      chk("t5_zero_mask_ignored", busy, 0);
    end

    // Reset in the middle of a ramp, then a clean conversion.
    thr[0] = 256; push_scan(4'b0001);
    kick(4'b0001);
    n = 0;
    do begin @(negedge clk); n++; end while (!(ramp_en && ridx == 50) && n < 200);
    chk("t6_ramp_at_50", ridx, 50);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk_reset_vals("t6");
    @(posedge clk); #1;
    rst = 1'b0;
    thr[0] = 20; log_q.delete(); push_scan(4'b0001);
    kick(4'b0001);
    wait_idle(200, "t6_idle");
    chk("t6_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("t6_data", log_q[0].data, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
